// File: rtl/arb8_pkg.sv
// arb8_pkg: shared types, constants and the rotate helper for the arb8 arbiter
package arb8_pkg;
    localparam int NREQ_DEF     = 8;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Rotate right by s so that bit (s-1) mod 8 lands at bit 7 for the rotating search
    function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] s);
        return 8'({v, v} >> s);
    endfunction
endpackage

// File: rtl/arb8_ctrl_prio_enc8.sv
// prio_enc8: 8-bit priority encoder, highest set index wins
module prio_enc8 (
    input  logic [7:0] in,
    output logic [2:0] idx,
    output logic       any
);
    // Later (higher) indices overwrite earlier ones, so the top set bit wins
    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (in[i]) idx = 3'(i);
    end

    assign any = |in;
endmodule

// File: rtl/arb8_ctrl.sv
// arb8_ctrl: eight-requester arbiter with grant hold, rotating priority and hold-time limit
module arb8_ctrl
    import arb8_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            rel,
    input  logic            rr_en,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_id,
    output logic            gnt_vld,
    output logic            tmo
);
    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      gnt_id_q, gnt_id_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic            tmo_q, tmo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      last_q, last_d;

    logic [7:0] enc_in;
    logic [2:0] enc_idx;
    logic       any;
    logic [2:0] win;
    logic       hold_hit;
    logic       vol_rel;
    logic       release_now;

    // In rotating mode the encoder sees req rotated by last; the index is rotated back mod 8
    assign enc_in = rr_en ? rotr8(req, last_q) : req;

    prio_enc8 u_enc (
        .in  (enc_in),
        .idx (enc_idx),
        .any (any)
    );

    assign win         = rr_en ? enc_idx + last_q : enc_idx;
    assign hold_hit    = (HOLD_MAX != 0) && (cnt_q == CW'(HOLD_MAX - 1));
    assign vol_rel     = rel || !req[gnt_id_q];
    assign release_now = vol_rel || hold_hit;

    // State and output registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    // Next state: arbitrate from IDLE, leave GRANT on any release condition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any ? GRANT : IDLE;
            GRANT:   state_d = release_now ? IDLE : GRANT;
            default: state_d = IDLE;
        endcase
    end

    // Next register values; tmo only when the hold limit alone ends the grant
    always_comb begin
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        tmo_d     = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    gnt_d     = NREQ'(1) << win;
                    gnt_id_d  = win;
                    gnt_vld_d = 1'b1;
                    cnt_d     = '0;
                    last_d    = win;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    cnt_d     = '0;
                    tmo_d     = !vol_rel;
                end else begin
                    cnt_d = (HOLD_MAX == 0 || hold_hit) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign tmo     = tmo_q;
endmodule

// File: tb/tb_arb8_ctrl.sv
// tb_arb8_ctrl: directed self-checking bench for arb8_ctrl
module tb_arb8_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic       rr_en = 1'b0;

    logic [7:0] gnt, gnt16;
    logic [2:0] gnt_id, gnt_id16;
    logic       gnt_vld, gnt_vld16;
    logic       tmo, tmo16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arb8_ctrl #(.NREQ(8), .HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .rr_en   (rr_en),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );

    arb8_ctrl dut16 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .rr_en   (rr_en),
        .gnt     (gnt16),
        .gnt_id  (gnt_id16),
        .gnt_vld (gnt_vld16),
        .tmo     (tmo16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] rr_seq [9];
        rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_id", {5'd0, gnt_id}, 8'd0);
        chk("rst_vld", {7'd0, gnt_vld}, 8'd0);
        chk("rst_tmo", {7'd0, tmo}, 8'd0);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_vld", {7'd0, gnt_vld}, 8'd0);
            chk("idle_gnt", gnt, 8'h00);
            chk("idle_tmo", {7'd0, tmo}, 8'd0);
        end

        req = 8'h24;
        tick();
        chk("fix_gnt", gnt, 8'h20);
        chk("fix_id", {5'd0, gnt_id}, 8'd5);
        chk("fix_vld", {7'd0, gnt_vld}, 8'd1);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("fix_rel_gnt", gnt, 8'h00);
        chk("fix_rel_vld", {7'd0, gnt_vld}, 8'd0);
        chk("fix_rel_tmo", {7'd0, tmo}, 8'd0);
        tick();
        chk("fix_regnt", gnt, 8'h20);
        req = 8'h00;
        tick();
        chk("fix_drop", gnt, 8'h00);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_en = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rr_id", {5'd0, gnt_id}, {5'd0, rr_seq[k]});
            chk("rr_gnt", gnt, 8'h01 << rr_seq[k]);
            rel = 1'b1;
            tick();
            rel = 1'b0;
            chk("rr_gap", {7'd0, gnt_vld}, 8'd0);
        end
        req = 8'h00;
        tick();

        req = 8'h20;
        tick();
        chk("rr5_id", {5'd0, gnt_id}, 8'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_gnt", gnt, 8'h00);
        chk("midrst_id", {5'd0, gnt_id}, 8'd0);
        chk("midrst_vld", {7'd0, gnt_vld}, 8'd0);
        chk("midrst_tmo", {7'd0, tmo}, 8'd0);
        req = 8'hFF;
        tick();
        chk("postrst_id", {5'd0, gnt_id}, 8'd7);
        req = 8'h00;
        tick();

        rr_en = 1'b0;
        req = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_vld", {7'd0, gnt_vld}, 8'd1);
            chk("hold_tmo", {7'd0, tmo}, 8'd0);
        end
        tick();
        chk("to_vld", {7'd0, gnt_vld}, 8'd0);
        chk("to_tmo", {7'd0, tmo}, 8'd1);
        tick();
        chk("to_regnt", gnt, 8'h01);
        chk("to_pulse_end", {7'd0, tmo}, 8'd0);
        req = 8'h00;
        tick();

        req = 8'h01;
        for (int i = 0; i < 4; i++) tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("coinc_vld", {7'd0, gnt_vld}, 8'd0);
        chk("coinc_tmo", {7'd0, tmo}, 8'd0);
        req = 8'h00;
        tick();

        req = 8'h08;
        tick();
        chk("c3_gnt", gnt, 8'h08);
        req = 8'h88;
        tick();
        chk("c3_nopreempt", gnt, 8'h08);
        req = 8'h80;
        tick();
        chk("c3_drop", gnt, 8'h00);
        chk("c3_drop_tmo", {7'd0, tmo}, 8'd0);
        tick();
        chk("c7_gnt", gnt, 8'h80);
        chk("c7_id", {5'd0, gnt_id}, 8'd7);
        req = 8'h00;
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h02;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("h16_vld", {7'd0, gnt_vld16}, 8'd1);
            chk("h16_tmo", {7'd0, tmo16}, 8'd0);
        end
        tick();
        chk("h16_end_vld", {7'd0, gnt_vld16}, 8'd0);
        chk("h16_end_tmo", {7'd0, tmo16}, 8'd1);
        req = 8'h00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
